// File: rtl/sr_cond_pkg.sv
// sr_input_conditioner shared types and defaults.
// Optional macro SR_COND_SYNC_EN adds a 2-flop input synchronizer.
package sr_cond_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SET_P,
        RST_P,
        CONFLICT
    } state_t;

    localparam int DB_CYCLES_DEF = 4;
    localparam int PULSE_LEN_DEF = 1;
    localparam int PCNT_W        = 4;

endpackage

// File: rtl/sr_input_conditioner_if.sv
// Raw request inputs and conditioned latch-drive outputs.
// master drives the raw lines, slave is the conditioner.
interface sr_input_conditioner_if;

    logic s_raw;
    logic r_raw;
    logic s_o;
    logic r_o;
    logic q_o;
    logic conflict_o;

    modport master (
        output s_raw, r_raw,
        input  s_o, r_o, q_o, conflict_o
    );

    modport slave (
        input  s_raw, r_raw,
        output s_o, r_o, q_o, conflict_o
    );

endinterface

// File: rtl/sr_cond_debounce.sv
// One-input synchronizer, debouncer and rise detector.
// SR_COND_SYNC_EN selects the 2-flop synchronizer on raw.
module sr_cond_debounce
    import sr_cond_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

    logic          din;
    logic [CW-1:0] cnt;

`ifdef SR_COND_SYNC_EN
    logic sync1;
    logic sync2;

    // two-flop synchronizer for the asynchronous request line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign din = sync2;
`else
    assign din = raw;
`endif

    // level follows din only after DB_CYCLES differing samples; rise marks 0->1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else if (din == level) begin
            cnt  <= '0;
            rise <= 1'b0;
        end else if (cnt == CMAX) begin
            cnt   <= '0;
            level <= ~level;
            rise  <= ~level;
        end else begin
            cnt  <= cnt + CW'(1);
            rise <= 1'b0;
        end
    end

endmodule

// File: rtl/sr_input_conditioner.sv
// Arbitrates debounced set/reset requests into exclusive pulses.
// Build macro SR_COND_SYNC_EN enables input synchronizers.
module sr_input_conditioner
    import sr_cond_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int PULSE_LEN = PULSE_LEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sr_input_conditioner_if.slave  bus
);

    localparam logic [PCNT_W-1:0] PLAST = PCNT_W'(PULSE_LEN - 1);

    logic s_lvl, s_rise;
    logic r_lvl, r_rise;

    state_t            state, state_n;
    logic [PCNT_W-1:0] pcnt, pcnt_n;
    logic              pend_s, pend_s_n;
    logic              pend_r, pend_r_n;
    logic              q, q_n;
    logic              s_q, r_q, c_q;
    logic              last;

    sr_cond_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_s (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.s_raw),
        .level (s_lvl),
        .rise  (s_rise)
    );

    sr_cond_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.r_raw),
        .level (r_lvl),
        .rise  (r_rise)
    );

    assign last = (pcnt == PLAST);

    // next state, pulse timing, pending requests and implied latch state
    always_comb begin
        state_n  = state;
        pcnt_n   = pcnt;
        pend_s_n = pend_s;
        pend_r_n = pend_r;
        q_n      = q;
        unique case (state)
            IDLE: begin
                pcnt_n   = '0;
                pend_s_n = 1'b0;
                pend_r_n = 1'b0;
                if ((s_lvl && r_lvl) || (s_rise && r_rise)) begin
                    state_n = CONFLICT;
                end else if (s_rise) begin
                    state_n = SET_P;
                    q_n     = 1'b1;
                end else if (r_rise) begin
                    state_n = RST_P;
                    q_n     = 1'b0;
                end
            end
            SET_P: begin
                pend_r_n = pend_r | r_rise;
                if (last) begin
                    pcnt_n   = '0;
                    pend_r_n = 1'b0;
                    if ((pend_r | r_rise) && r_lvl && !s_lvl) begin
                        state_n = RST_P;
                        q_n     = 1'b0;
                    end else if (s_lvl && r_lvl) begin
                        state_n = CONFLICT;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    pcnt_n = pcnt + PCNT_W'(1);
                end
            end
            RST_P: begin
                pend_s_n = pend_s | s_rise;
                if (last) begin
                    pcnt_n   = '0;
                    pend_s_n = 1'b0;
                    if ((pend_s | s_rise) && s_lvl && !r_lvl) begin
                        state_n = SET_P;
                        q_n     = 1'b1;
                    end else if (s_lvl && r_lvl) begin
                        state_n = CONFLICT;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    pcnt_n = pcnt + PCNT_W'(1);
                end
            end
            CONFLICT: begin
                pcnt_n = '0;
                if (!s_lvl && !r_lvl) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // state plus outputs registered from the next state so they align
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pcnt   <= '0;
            pend_s <= 1'b0;
            pend_r <= 1'b0;
            q      <= 1'b0;
            s_q    <= 1'b0;
            r_q    <= 1'b0;
            c_q    <= 1'b0;
        end else begin
            state  <= state_n;
            pcnt   <= pcnt_n;
            pend_s <= pend_s_n;
            pend_r <= pend_r_n;
            q      <= q_n;
            s_q    <= (state_n == SET_P);
            r_q    <= (state_n == RST_P);
            c_q    <= (state_n == CONFLICT);
        end
    end

    assign bus.s_o        = s_q;
    assign bus.r_o        = r_q;
    assign bus.q_o        = q;
    assign bus.conflict_o = c_q;

endmodule
